// File: rtl/spk_write_packer.sv
// Packs a stream of 2-bit spike codes into DATA_W-bit words, code k in bits [2k+1:2k],
// and issues each full or flushed word as a one-cycle write at an auto-incrementing address.
module spk_write_packer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              spk_in_valid,
  input  logic [1:0]        spk_in_data,
  output logic              spk_in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] spk_write_in,
  output logic [ADDR_W-1:0] cntrl_spk_write_addr,
  output logic              cntrl_spk_write_we,
  output logic              busy,
  output logic              done,
  output logic              addr_wrap
);

  localparam int FIELDS = DATA_W / 2;
  localparam int SLOT_W = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FIELDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic                wrap_q, wrap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (spk_in_valid) begin
          if (slot_q == LAST_SLOT || flush) state_d = WRITE;
        end else if (flush) begin
          state_d = (slot_q == '0) ? DONE : WRITE;
        end
      end
      WRITE:   state_d = last_q ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spk_in_ready       = (state_q == FILL);
    cntrl_spk_write_we = (state_q == WRITE);
    busy               = (state_q != IDLE);
    done               = (state_q == DONE);
  end

  // Datapath: an accepted code is packed before any simultaneous flush takes effect.
  always_comb begin
    word_d = word_q;
    slot_d = slot_q;
    addr_d = addr_q;
    last_d = last_q;
    wrap_d = wrap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          slot_d = '0;
          word_d = '0;
          last_d = 1'b0;
          wrap_d = 1'b0;
        end
      end
      FILL: begin
        if (spk_in_valid) begin
          for (int k = 0; k < FIELDS; k++) begin
            if (slot_q == SLOT_W'(k)) word_d[2*k +: 2] = spk_in_data;
          end
          slot_d = slot_q + SLOT_W'(1);
          if (slot_q == LAST_SLOT || flush) last_d = flush;
        end else if (flush && slot_q != '0) begin
          last_d = 1'b1;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (&addr_q) wrap_d = 1'b1;
        word_d = '0;
        slot_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      slot_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      word_q <= word_d;
      slot_q <= slot_d;
      addr_q <= addr_d;
      last_q <= last_d;
      wrap_q <= wrap_d;
    end
  end

  assign spk_write_in         = word_q;
  assign cntrl_spk_write_addr = addr_q;
  assign addr_wrap            = wrap_q;

endmodule
